p19_uart_rx: RTL
================

P19_UART_RX -- requirements
Module: p19_uart_rx

Interface
REQ-001 SHALL have parameter BIT_RATE, default 9600, line bit rate in bits/s.
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have port clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port uart_rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-008 SHALL have port uart_rx_en  input  1  receive enable; gates frame start only.
REQ-009 SHALL have port uart_rx_valid  output  1  one-cycle pulse: new frame on uart_rx_data.
REQ-010 SHALL have port uart_rx_data  output  PAYLOAD_BITS  last received payload, LSB first on line.
REQ-011 SHALL have port uart_rx_frame_err  output  1  qualified by valid: a stop bit sampled low.
REQ-012 SHALL have port uart_rx_break  output  1  qualified by valid: payload all zero and frame error.

Function
REQ-013 SHALL compute CYCLES_PER_BIT = (1e9/BIT_RATE)/(1e9/CLK_HZ) in integer ns arithmetic, HALF_BIT = CYCLES_PER_BIT/2 (floor).
REQ-014 SHALL size the cycle counter at 1+clog2(CYCLES_PER_BIT) bits; no wrap within a bit period.
REQ-015 SHALL pass uart_rxd through a 2-flop synchronizer (rxd_s), reset value 1; all decisions use rxd_s only.
REQ-016 SHALL implement states IDLE, START, DATA, STOP; reset state IDLE.
REQ-017 IDLE: counter held 0; on rxd_s==0 and uart_rx_en==1 -> START.
REQ-018 START: counter increments; at counter==HALF_BIT, rxd_s==0 -> DATA with counter cleared; rxd_s==1 -> IDLE (false start, no valid).
REQ-019 DATA: at counter==CYCLES_PER_BIT sample rxd_s into shift register MSB, shift right, clear counter; after PAYLOAD_BITS samples -> STOP.
REQ-020 STOP: sample rxd_s at each counter==CYCLES_PER_BIT; any low sample sets frame error; after STOP_BITS samples -> IDLE.
REQ-021 Exit from STOP SHALL register uart_rx_data, frame_err, break and assert uart_rx_valid for exactly one cycle (the cycle after the last stop sample).
REQ-022 uart_rx_data/frame_err/break SHALL hold until the next valid pulse.
REQ-023 Deasserting uart_rx_en mid-frame SHALL NOT abort the frame; it only blocks the next START.
REQ-024 Back-to-back frames: a start edge in the first cycle after return to IDLE SHALL be accepted.
REQ-025 Line held low after a frame error SHALL NOT start a new frame until rxd_s has been seen high in IDLE.

Reset
REQ-026 resetn low SHALL asynchronously force: state IDLE, counter 0, synchronizer flops 1, shift register 0, uart_rx_data 0, uart_rx_valid 0, uart_rx_frame_err 0, uart_rx_break 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no valid pulse follows release.

Structure
REQ-028 CYCLES_PER_BIT/count-width derivation SHALL live in shared package p19_uart_pkg, used by both p19_uart_rx and p19_uart_tx.
REQ-029 The synchronizer SHALL be sub-module p19_sync2 (2 flops, reset value parameter).
REQ-030 No other sub-modules; FSM, counter and shift register in p19_uart_rx.

Verification (CLK_HZ=50_000_000, BIT_RATE=1_000_000 -> CYCLES_PER_BIT=50, HALF_BIT=25)
REQ-031 Frame 0xA5, 1 stop -> one valid pulse, data=0xA5, frame_err=0, break=0, ~10 bit times after start edge.
REQ-032 Low glitch of 10 cycles in IDLE -> return to IDLE, no valid.
REQ-033 0x3C with stop bit low, then line high -> valid, data=0x3C, frame_err=1, break=0; line held low 20 bit times -> data=0x00, frame_err=1, break=1, single valid.
REQ-034 Frames 0x01, 0xFF back-to-back, zero idle -> two valid pulses, data 0x01 then 0xFF.
REQ-035 resetn pulsed low mid-bit 4 of a frame -> all outputs reset at once, no valid, next clean frame 0x5A received correctly.
REQ-036 uart_rx_en=0 during start edge -> no frame; en dropped mid-frame -> frame completes with valid.

Source files
------------

// File: rtl/p19_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p19_uart_pkg
// Description : Shared UART timing derivation and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package p19_uart_pkg;

  // Receiver frame states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int NS_PER_S = 1_000_000_000;

  // Clock cycles per line bit, computed through integer nanosecond periods
  // so that rx and tx agree exactly on rounding.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return (NS_PER_S / bit_rate) / (NS_PER_S / clk_hz);
  endfunction

  // One spare bit so the counter can reach CYCLES_PER_BIT without wrapping.
  function automatic int count_width(input int cpb);
    return 1 + $clog2(cpb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/p19_sync2.sv
`default_nettype none
// ============================================================================
// Module      : p19_sync2
// Description : Two-flop synchronizer with configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module p19_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to settle the asynchronous input
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/p19_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : p19_uart_rx
// Description : UART receiver, mid-bit sampling, configurable payload and
//               stop bits, with frame-error and break reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module p19_uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  import p19_uart_pkg::*;

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = count_width(CYCLES_PER_BIT);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(HALF_BIT);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  rx_state_t               state;
  rx_state_t               state_nxt;
  logic                    rxd_s;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [1:0]              stop_cnt;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic [PAYLOAD_BITS-1:0] shift_nxt;
  logic                    stop_err;
  logic                    armed;

  logic half_hit;
  logic full_hit;
  logic start_ok;
  logic in_idle;
  logic cnt_clr;
  logic sample_data;
  logic sample_stop;
  logic frame_done;
  logic frame_err_now;

  p19_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxd_s)
  );

  assign half_hit      = (cnt == HALF_CNT);
  assign full_hit      = (cnt == FULL_CNT);
  assign in_idle       = (state == ST_IDLE);
  // A line stuck low after an error must first be seen high before re-arming.
  assign start_ok      = !rxd_s && uart_rx_en && armed;
  assign frame_err_now = stop_err | ~rxd_s;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_START;
      ST_START: if (half_hit) state_nxt = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (full_hit && (bit_cnt == LAST_BIT)) state_nxt = ST_STOP;
      ST_STOP:  if (full_hit && (stop_cnt == LAST_STOP)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    cnt_clr     = 1'b0;
    sample_data = 1'b0;
    sample_stop = 1'b0;
    frame_done  = 1'b0;
    case (state)
      ST_IDLE:  cnt_clr = 1'b1;
      ST_START: cnt_clr = half_hit;
      ST_DATA: begin
        cnt_clr     = full_hit;
        sample_data = full_hit;
      end
      ST_STOP: begin
        cnt_clr     = full_hit;
        sample_stop = full_hit;
        frame_done  = full_hit && (stop_cnt == LAST_STOP);
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit-period cycle counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  // Data and stop bit counters plus the sticky stop-bit error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt  <= '0;
      stop_cnt <= '0;
      stop_err <= 1'b0;
    end else if (in_idle) begin
      bit_cnt  <= '0;
      stop_cnt <= '0;
      stop_err <= 1'b0;
    end else begin
      if (sample_data) bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      if (sample_stop) begin
        stop_cnt <= stop_cnt + 1'b1;
        stop_err <= frame_err_now;
      end
    end
  end

  // Line is LSB first: new bit enters at the MSB and the word shifts right.
  generate
    if (PAYLOAD_BITS > 1) begin : g_shift_wide
      assign shift_nxt = {rxd_s, shift_reg[PAYLOAD_BITS-1:1]};
    end else begin : g_shift_one
      assign shift_nxt = rxd_s;
    end
  endgenerate

  // Receive shift register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          shift_reg <= '0;
    else if (sample_data) shift_reg <= shift_nxt;
  end

  // Start qualification: cleared by a framing error, restored by an idle-high line
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         armed <= 1'b1;
    else if (in_idle && rxd_s)           armed <= 1'b1;
    else if (frame_done && frame_err_now) armed <= 1'b0;
  end

  // Output registers, updated only when a frame completes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_rx_valid     <= 1'b0;
      uart_rx_data      <= '0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
    end else begin
      uart_rx_valid <= frame_done;
      if (frame_done) begin
        uart_rx_data      <= shift_reg;
        uart_rx_frame_err <= frame_err_now;
        uart_rx_break     <= frame_err_now && (shift_reg == '0);
      end
    end
  end

endmodule
`default_nettype wire
